// File: rtl/apb_cmd_master.sv
// APB initiator: turns one valid/ready command into a SETUP->ACCESS transfer and
// returns read data / error / timeout status on a valid/ready response channel.
module apb_cmd_master #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        pclk,
  input  logic        preset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_strb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_slverr,
  output logic        rsp_timeout,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             live;
  logic             rdy;
  logic             last_wait;

  // X/Z on pready must never complete a transfer
  assign rdy       = (pready === 1'b1);
  assign last_wait = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // live keeps cmd_ready low while reset is held, even though state sits in IDLE
  assign cmd_ready = live && (state == IDLE);
  assign psel      = (state == SETUP) || (state == ACCESS);
  assign penable   = (state == ACCESS);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state       <= IDLE;
      live        <= 1'b0;
      cnt         <= '0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      live <= 1'b1;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            if (cmd_write) pwdata <= cmd_wdata;
            pstrb  <= cmd_write ? cmd_strb : 4'h0;
            cnt    <= '0;
            state  <= SETUP;
          end
        end
        SETUP: state <= ACCESS;
        ACCESS: begin
          cnt <= cnt + 1'b1;
          // pready wins over a coincident timeout
          if (rdy) begin
            rsp_rdata   <= pwrite ? 32'h0 : prdata;
            rsp_slverr  <= pslverr;
            rsp_timeout <= 1'b0;
            state       <= RESP;
          end else if (last_wait) begin
            rsp_rdata   <= 32'h0;
            rsp_slverr  <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
